// File: rtl/ctrl_pkg.sv
// ctrl_pkg
//    Shared definitions for the 16-bit pipeline control blocks.
//    Contents:
//       IR_W, OP_W        instruction and opcode field widths
//       OP_*              opcode constants, branch prefix
//       IR_NOP            NOP instruction encoding
//       wb_state_t        writeback load FSM states
//       writes_reg(ir)    1 when the instruction writes the register file
package ctrl_pkg;

   localparam int IR_W = 16;
   localparam int OP_W = 5;

   localparam logic [OP_W-1:0] OP_NOP    = 5'b00000;
   localparam logic [OP_W-1:0] OP_LDR    = 5'b01101;
   localparam logic [OP_W-1:0] OP_STR    = 5'b01110;
   // Every opcode starting with 2'b11 is a branch.
   localparam logic [1:0]      OP_BR_PFX = 2'b11;

   localparam logic [IR_W-1:0] IR_NOP = '0;

   typedef enum logic [1:0] {
      RUN,
      WAIT,
      DONE
   } wb_state_t;

   function automatic logic writes_reg(input logic [IR_W-1:0] ir);
      logic [OP_W-1:0] op;
      op = ir[IR_W-1 -: OP_W];
      return (op != OP_NOP) && (op != OP_STR) && (op[OP_W-1 -: 2] != OP_BR_PFX);
   endfunction

endpackage

// File: rtl/wb_ld_timer.sv
// wb_ld_timer
//    Stall-cycle counter for an outstanding load in writeback.
//    Ports:
//       clk        clock, rising edge
//       rst        asynchronous, active-low reset (count cleared to 0)
//       i_load     set count to 1 (first stall cycle)
//       i_inc      increment count, saturating at LD_TIMEOUT
//       o_expired  count has reached LD_TIMEOUT
module wb_ld_timer #(
   parameter int LD_TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic i_load,
   input  logic i_inc,
   output logic o_expired
);

   localparam int CNT_W = $clog2(LD_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LD_TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (i_load) begin
         cnt_d = CNT_ONE;
      end else if (i_inc && (cnt_q != CNT_MAX)) begin
         // Saturate rather than wrap, so a stray increment can never
         // make an expired count look fresh again.
         cnt_d = cnt_q + CNT_ONE;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign o_expired = (cnt_q == CNT_MAX);

endmodule

// File: rtl/ctrl_wb_ld.sv
// ctrl_wb_ld
//    Writeback-stage controller: owns the MEM->WB pipeline register,
//    selects ALU or load data for the register-file write port and
//    stalls the pipeline while an LDR waits for late load data.
//    Ports:
//       clk, rst               clock; asynchronous active-low reset
//       i_ir_mem, i_alu_mem    instruction / ALU result leaving MEM
//       i_stall, i_flush       hold WB register / capture NOP instead
//       i_ld_valid, i_ld_data  load response (single-cycle valid)
//       o_ir_wb                instruction currently in WB
//       o_rd_sel               WB holds an LDR (load data path)
//       o_rf_we/waddr/wdata    register-file write port
//       o_stall_req            WB requests a global stall
//       o_ld_err               one-cycle pulse: load timed out, write dropped
module ctrl_wb_ld
   import ctrl_pkg::*;
#(
   parameter int DATA_W     = 16,
   parameter int REG_ADDR_W = 3,
   parameter int LD_TIMEOUT = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [IR_W-1:0]       i_ir_mem,
   input  logic [DATA_W-1:0]     i_alu_mem,
   input  logic                  i_stall,
   input  logic                  i_flush,
   input  logic                  i_ld_valid,
   input  logic [DATA_W-1:0]     i_ld_data,
   output logic [IR_W-1:0]       o_ir_wb,
   output logic                  o_rd_sel,
   output logic                  o_rf_we,
   output logic [REG_ADDR_W-1:0] o_rf_waddr,
   output logic [DATA_W-1:0]     o_rf_wdata,
   output logic                  o_stall_req,
   output logic                  o_ld_err
);

   wb_state_t         state_q, state_d;
   logic [IR_W-1:0]   ir_wb_q, ir_wb_d;
   logic [DATA_W-1:0] alu_wb_q, alu_wb_d;

   logic is_ldr;
   logic tmr_load;
   logic tmr_inc;
   logic tmr_expired;
   logic wb_load;

   assign is_ldr = (ir_wb_q[IR_W-1 -: OP_W] == OP_LDR);

   wb_ld_timer #(
      .LD_TIMEOUT (LD_TIMEOUT)
   ) u_timer (
      .clk       (clk),
      .rst       (rst),
      .i_load    (tmr_load),
      .i_inc     (tmr_inc),
      .o_expired (tmr_expired)
   );

   always_comb begin
      state_d     = state_q;
      o_rf_we     = 1'b0;
      o_rf_wdata  = alu_wb_q;
      o_stall_req = 1'b0;
      o_ld_err    = 1'b0;
      tmr_load    = 1'b0;
      tmr_inc     = 1'b0;

      case (state_q)
         RUN: begin
            if (!is_ldr) begin
               o_rf_we = writes_reg(ir_wb_q);
            end else if (i_ld_valid) begin
               o_rf_we    = 1'b1;
               o_rf_wdata = i_ld_data;
               // If the LDR stays parked by i_stall, DONE keeps it from
               // issuing a second load wait next cycle.
               state_d    = i_stall ? DONE : RUN;
            end else begin
               o_stall_req = 1'b1;
               tmr_load    = 1'b1;
               state_d     = WAIT;
            end
         end
         WAIT: begin
            if (i_ld_valid) begin
               o_rf_we    = 1'b1;
               o_rf_wdata = i_ld_data;
               state_d    = i_stall ? DONE : RUN;
            end else if (tmr_expired) begin
               o_ld_err = 1'b1;
               state_d  = i_stall ? DONE : RUN;
            end else begin
               o_stall_req = 1'b1;
               tmr_inc     = 1'b1;
            end
         end
         DONE: begin
            // Late load responses are ignored here; wait for the hold to drop.
            if (!i_stall) begin
               state_d = RUN;
            end
         end
         default: begin
            state_d = RUN;
         end
      endcase

      // The WB register advances only when no one is holding the pipe.
      wb_load  = !i_stall && !o_stall_req;
      ir_wb_d  = ir_wb_q;
      alu_wb_d = alu_wb_q;
      if (wb_load) begin
         ir_wb_d  = i_flush ? IR_NOP : i_ir_mem;
         alu_wb_d = i_flush ? '0 : i_alu_mem;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= RUN;
         ir_wb_q  <= IR_NOP;
         alu_wb_q <= '0;
      end else begin
         state_q  <= state_d;
         ir_wb_q  <= ir_wb_d;
         alu_wb_q <= alu_wb_d;
      end
   end

   assign o_ir_wb    = ir_wb_q;
   assign o_rd_sel   = is_ldr;
   assign o_rf_waddr = ir_wb_q[10 -: REG_ADDR_W];

endmodule

// File: tb/tb_ctrl_wb_ld.sv
// tb_ctrl_wb_ld
//    Bench for ctrl_wb_ld with LD_TIMEOUT=4. Register-file writes are
//    checked against a queue of expected {waddr, wdata} pushed when the
//    producing instruction is driven; each scenario task also checks the
//    per-cycle control flags inline.
module tb_ctrl_wb_ld;

   localparam int DATA_W     = 16;
   localparam int REG_ADDR_W = 3;
   localparam int LD_TIMEOUT = 4;

   localparam logic [4:0] T_ADD = 5'b00001;
   localparam logic [4:0] T_LDR = 5'b01101;
   localparam logic [4:0] T_STR = 5'b01110;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [15:0]           i_ir_mem;
   logic [DATA_W-1:0]     i_alu_mem;
   logic                  i_stall;
   logic                  i_flush;
   logic                  i_ld_valid;
   logic [DATA_W-1:0]     i_ld_data;
   logic [15:0]           o_ir_wb;
   logic                  o_rd_sel;
   logic                  o_rf_we;
   logic [REG_ADDR_W-1:0] o_rf_waddr;
   logic [DATA_W-1:0]     o_rf_wdata;
   logic                  o_stall_req;
   logic                  o_ld_err;

   // {we, stall_req, ld_err, rd_sel}
   logic [3:0] flags;
   assign flags = {o_rf_we, o_stall_req, o_ld_err, o_rd_sel};

   int vectors     = 0;
   int miscompares = 0;
   logic [REG_ADDR_W+DATA_W-1:0] exp_q[$];

   always #5 clk = ~clk;

   ctrl_wb_ld #(
      .DATA_W     (DATA_W),
      .REG_ADDR_W (REG_ADDR_W),
      .LD_TIMEOUT (LD_TIMEOUT)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .i_ir_mem    (i_ir_mem),
      .i_alu_mem   (i_alu_mem),
      .i_stall     (i_stall),
      .i_flush     (i_flush),
      .i_ld_valid  (i_ld_valid),
      .i_ld_data   (i_ld_data),
      .o_ir_wb     (o_ir_wb),
      .o_rd_sel    (o_rd_sel),
      .o_rf_we     (o_rf_we),
      .o_rf_waddr  (o_rf_waddr),
      .o_rf_wdata  (o_rf_wdata),
      .o_stall_req (o_stall_req),
      .o_ld_err    (o_ld_err)
   );

   function automatic logic [15:0] mk_ir(input logic [4:0] op, input logic [2:0] rd);
      return {op, rd, 8'h00};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: every register-file write must match the oldest expectation.
   always @(negedge clk) begin : sb_monitor
      logic [REG_ADDR_W+DATA_W-1:0] exp_w;
      if (rst && o_rf_we) begin
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL sb_write: got write r%0d=%h, required no write", o_rf_waddr, o_rf_wdata);
         end else begin
            exp_w = exp_q.pop_front();
            if ({o_rf_waddr, o_rf_wdata} !== exp_w) begin
               miscompares++;
               $display("FAIL sb_write: got r%0d=%h, required r%0d=%h",
                        o_rf_waddr, o_rf_wdata, exp_w[DATA_W +: REG_ADDR_W], exp_w[DATA_W-1:0]);
            end else begin
               $display("write r%0d <= %h", o_rf_waddr, o_rf_wdata);
            end
         end
      end
   end

   task automatic test_reset();
      rst = 1'b0; i_ir_mem = '0; i_alu_mem = '0; i_stall = 1'b0; i_flush = 1'b0;
      i_ld_valid = 1'b0; i_ld_data = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      vectors++; if (flags !== 4'b0000) begin miscompares++; $display("FAIL reset_flags: got %b required 0000", flags); end
      vectors++; if (o_ir_wb !== 16'h0000) begin miscompares++; $display("FAIL reset_ir: got %h required 0000", o_ir_wb); end
      vectors++; if (o_rf_wdata !== 16'h0000) begin miscompares++; $display("FAIL reset_wdata: got %h required 0000", o_rf_wdata); end
      tick();
      rst = 1'b1;
      $display("reset released");
   endtask

   task automatic test_alu_write();
      i_ir_mem = mk_ir(T_ADD, 3'd3); i_alu_mem = 16'h1234;
      exp_q.push_back({3'd3, 16'h1234});
      tick();
      i_ir_mem = '0; i_alu_mem = '0;
      @(negedge clk);
      vectors++; if (flags !== 4'b1000) begin miscompares++; $display("FAIL alu_flags: got %b required 1000", flags); end
      vectors++; if (o_rf_waddr !== 3'd3) begin miscompares++; $display("FAIL alu_waddr: got %0d required 3", o_rf_waddr); end
      vectors++; if (o_rf_wdata !== 16'h1234) begin miscompares++; $display("FAIL alu_wdata: got %h required 1234", o_rf_wdata); end
      tick();
      @(negedge clk);
      vectors++; if (flags !== 4'b0000) begin miscompares++; $display("FAIL alu_after_flags: got %b required 0000", flags); end
   endtask

   task automatic test_ldr_same_cycle();
      i_ir_mem = mk_ir(T_LDR, 3'd5);
      tick();
      i_ir_mem = '0; i_ld_valid = 1'b1; i_ld_data = 16'hBEEF;
      exp_q.push_back({3'd5, 16'hBEEF});
      @(negedge clk);
      vectors++; if (flags !== 4'b1001) begin miscompares++; $display("FAIL ld0_flags: got %b required 1001", flags); end
      vectors++; if (o_rf_wdata !== 16'hBEEF) begin miscompares++; $display("FAIL ld0_wdata: got %h required beef", o_rf_wdata); end
      tick();
      i_ld_valid = 1'b0;
      @(negedge clk);
      vectors++; if (flags !== 4'b0000) begin miscompares++; $display("FAIL ld0_next_flags: got %b required 0000", flags); end
      vectors++; if (o_ir_wb !== 16'h0000) begin miscompares++; $display("FAIL ld0_next_ir: got %h required 0000", o_ir_wb); end
   endtask

   task automatic test_ldr_late();
      logic [15:0] ldr_ir;
      logic [15:0] add_ir;
      ldr_ir = mk_ir(T_LDR, 3'd2);
      add_ir = mk_ir(T_ADD, 3'd1);
      i_ir_mem = ldr_ir;
      exp_q.push_back({3'd2, 16'h00AA});
      tick();
      i_ir_mem = add_ir; i_alu_mem = 16'h0055;
      exp_q.push_back({3'd1, 16'h0055});
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         vectors++; if (flags !== 4'b0101) begin miscompares++; $display("FAIL late_c%0d_flags: got %b required 0101", c, flags); end
         vectors++; if (o_ir_wb !== ldr_ir) begin miscompares++; $display("FAIL late_c%0d_ir: got %h required %h", c, o_ir_wb, ldr_ir); end
         tick();
      end
      i_ld_valid = 1'b1; i_ld_data = 16'h00AA;
      @(negedge clk);
      vectors++; if (flags !== 4'b1001) begin miscompares++; $display("FAIL late_c2_flags: got %b required 1001", flags); end
      tick();
      i_ld_valid = 1'b0; i_ir_mem = '0; i_alu_mem = '0;
      @(negedge clk);
      vectors++; if (o_ir_wb !== add_ir) begin miscompares++; $display("FAIL late_c3_ir: got %h required %h", o_ir_wb, add_ir); end
      vectors++; if (flags !== 4'b1000) begin miscompares++; $display("FAIL late_c3_flags: got %b required 1000", flags); end
      tick();
   endtask

   task automatic test_ldr_timeout();
      logic [15:0] ldr_ir;
      logic [15:0] add_ir;
      ldr_ir = mk_ir(T_LDR, 3'd6);
      add_ir = mk_ir(T_ADD, 3'd4);
      i_ir_mem = ldr_ir;
      tick();
      i_ir_mem = add_ir; i_alu_mem = 16'h0777;
      exp_q.push_back({3'd4, 16'h0777});
      for (int c = 0; c < LD_TIMEOUT; c++) begin
         @(negedge clk);
         vectors++; if (flags !== 4'b0101) begin miscompares++; $display("FAIL to_c%0d_flags: got %b required 0101", c, flags); end
         vectors++; if (o_ir_wb !== ldr_ir) begin miscompares++; $display("FAIL to_c%0d_ir: got %h required %h", c, o_ir_wb, ldr_ir); end
         tick();
      end
      @(negedge clk);
      vectors++; if (flags !== 4'b0011) begin miscompares++; $display("FAIL to_err_flags: got %b required 0011", flags); end
      tick();
      i_ir_mem = '0; i_alu_mem = '0;
      @(negedge clk);
      vectors++; if (o_ir_wb !== add_ir) begin miscompares++; $display("FAIL to_next_ir: got %h required %h", o_ir_wb, add_ir); end
      vectors++; if (flags !== 4'b1000) begin miscompares++; $display("FAIL to_next_flags: got %b required 1000", flags); end
      tick();
   endtask

   task automatic test_ldr_held_stall();
      logic [15:0] ldr_ir;
      logic [15:0] add_ir;
      ldr_ir = mk_ir(T_LDR, 3'd7);
      add_ir = mk_ir(T_ADD, 3'd1);
      i_ir_mem = ldr_ir;
      tick();
      i_ir_mem = add_ir; i_alu_mem = 16'h0011;
      i_stall = 1'b1; i_ld_valid = 1'b1; i_ld_data = 16'h5A5A;
      exp_q.push_back({3'd7, 16'h5A5A});
      exp_q.push_back({3'd1, 16'h0011});
      @(negedge clk);
      vectors++; if (flags !== 4'b1001) begin miscompares++; $display("FAIL hold_c0_flags: got %b required 1001", flags); end
      for (int c = 1; c <= 4; c++) begin
         tick();
         // cycle 2 carries a late, unexpected load response; cycle 4 drops the hold
         i_ld_valid = (c == 2);
         i_ld_data  = 16'hDEAD;
         i_stall    = (c != 4);
         @(negedge clk);
         vectors++; if (flags !== 4'b0001) begin miscompares++; $display("FAIL hold_c%0d_flags: got %b required 0001", c, flags); end
         vectors++; if (o_ir_wb !== ldr_ir) begin miscompares++; $display("FAIL hold_c%0d_ir: got %h required %h", c, o_ir_wb, ldr_ir); end
      end
      tick();
      i_ld_valid = 1'b0; i_ir_mem = '0; i_alu_mem = '0;
      @(negedge clk);
      vectors++; if (o_ir_wb !== add_ir) begin miscompares++; $display("FAIL hold_next_ir: got %h required %h", o_ir_wb, add_ir); end
      vectors++; if (flags !== 4'b1000) begin miscompares++; $display("FAIL hold_next_flags: got %b required 1000", flags); end
      tick();
   endtask

   task automatic test_no_write_flush();
      logic [15:0] tbl [4];
      tbl[0] = mk_ir(T_STR, 3'd1);
      tbl[1] = mk_ir(5'b11010, 3'd2);
      tbl[2] = 16'h0000;
      tbl[3] = mk_ir(5'b11111, 3'd3);
      for (int i = 0; i < 4; i++) begin
         i_ir_mem = tbl[i]; i_alu_mem = 16'hFFFF;
         tick();
         @(negedge clk);
         vectors++; if (o_ir_wb !== tbl[i]) begin miscompares++; $display("FAIL nowr%0d_ir: got %h required %h", i, o_ir_wb, tbl[i]); end
         vectors++; if (flags !== 4'b0000) begin miscompares++; $display("FAIL nowr%0d_flags: got %b required 0000", i, flags); end
      end
      i_ir_mem = mk_ir(T_ADD, 3'd2); i_alu_mem = 16'h2222; i_flush = 1'b1;
      tick();
      i_flush = 1'b0; i_ir_mem = '0; i_alu_mem = '0;
      @(negedge clk);
      vectors++; if (o_ir_wb !== 16'h0000) begin miscompares++; $display("FAIL flush_ir: got %h required 0000", o_ir_wb); end
      vectors++; if (flags !== 4'b0000) begin miscompares++; $display("FAIL flush_flags: got %b required 0000", flags); end
      i_ir_mem = mk_ir(T_ADD, 3'd3); i_alu_mem = 16'h0333;
      exp_q.push_back({3'd3, 16'h0333});
      tick();
      i_flush = 1'b1; i_ir_mem = mk_ir(T_ADD, 3'd4); i_alu_mem = 16'h0444;
      @(negedge clk);
      vectors++; if (flags !== 4'b1000) begin miscompares++; $display("FAIL flush_keep_flags: got %b required 1000", flags); end
      tick();
      i_flush = 1'b0; i_ir_mem = '0; i_alu_mem = '0;
      @(negedge clk);
      vectors++; if (o_ir_wb !== 16'h0000) begin miscompares++; $display("FAIL flush_keep_ir: got %h required 0000", o_ir_wb); end
   endtask

   task automatic test_reset_mid_wait();
      i_ir_mem = mk_ir(T_LDR, 3'd1);
      tick();
      i_ir_mem = '0;
      @(negedge clk);
      vectors++; if (flags !== 4'b0101) begin miscompares++; $display("FAIL rmw_c0_flags: got %b required 0101", flags); end
      tick();
      @(negedge clk);
      vectors++; if (flags !== 4'b0101) begin miscompares++; $display("FAIL rmw_c1_flags: got %b required 0101", flags); end
      #2;
      rst = 1'b0;
      #1;
      vectors++; if (flags !== 4'b0000) begin miscompares++; $display("FAIL rmw_rst_flags: got %b required 0000", flags); end
      vectors++; if (o_ir_wb !== 16'h0000) begin miscompares++; $display("FAIL rmw_rst_ir: got %h required 0000", o_ir_wb); end
      tick();
      i_ld_valid = 1'b1; i_ld_data = 16'h1111;
      @(negedge clk);
      vectors++; if (flags !== 4'b0000) begin miscompares++; $display("FAIL rmw_hold_flags: got %b required 0000", flags); end
      tick();
      i_ld_valid = 1'b0; rst = 1'b1;
      i_ir_mem = mk_ir(T_LDR, 3'd4);
      tick();
      i_ir_mem = '0; i_ld_valid = 1'b1; i_ld_data = 16'h4444;
      exp_q.push_back({3'd4, 16'h4444});
      @(negedge clk);
      vectors++; if (flags !== 4'b1001) begin miscompares++; $display("FAIL rmw_ld_flags: got %b required 1001", flags); end
      tick();
      i_ld_valid = 1'b0;
      @(negedge clk);
      vectors++; if (flags !== 4'b0000) begin miscompares++; $display("FAIL rmw_after_flags: got %b required 0000", flags); end
      vectors++; if (o_ld_err !== 1'b0) begin miscompares++; $display("FAIL rmw_err: got %b required 0", o_ld_err); end
   endtask

   initial begin
      test_reset();
      test_alu_write();
      test_ldr_same_cycle();
      test_ldr_late();
      test_ldr_timeout();
      test_ldr_held_stall();
      test_no_write_flush();
      test_reset_mid_wait();
      tick();
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL sb_drain: got %0d writes outstanding, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

endmodule

// File: doc/ctrl_wb_ld.md
# ctrl_wb_ld

Writeback-stage controller for the 16-bit pipelined core, parametrised in data width, register-file size and load timeout. It owns the WB pipeline register and decodes register-file writes. It selects ALU or load data and stalls the pipeline while an LDR waits for a memory response that arrives late. It sits between the MEM-stage outputs and the register-file write port, and feeds the hazard unit.

## Interface
- DATA_W, 16, register/ALU/load data width
- REG_ADDR_W, 3, register index width (rd = i_ir[10 -: REG_ADDR_W])
- LD_TIMEOUT, 16, maximum stall cycles waiting for load data (≥2)

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- i_ir_mem  in  16  instruction leaving MEM
- i_alu_mem  in  DATA_W  ALU result leaving MEM
- i_stall  in  1  external stall from other stages (hold WB register)
- i_flush  in  1  capture NOP instead of i_ir_mem
- i_ld_valid  in  1  load data valid (single-cycle pulse)
- i_ld_data  in  DATA_W  load data
- o_ir_wb  out  16  instruction currently in WB
- o_rd_sel  out  1  1 when WB holds LDR (load data path selected)
- o_rf_we  out  1  register-file write enable
- o_rf_waddr  out  REG_ADDR_W  write index
- o_rf_wdata  out  DATA_W  write data
- o_stall_req  out  1  WB requests global stall
- o_ld_err  out  1  one-cycle pulse: load timed out, write dropped

## Operation
- Opcode = ir[15:11]. LDR = 5'b01101, NOP = 5'b00000, STR = 5'b01110, branches = 5'b11???.
- Writes-register(ir) = opcode not NOP, STR or branch.
- WB register (ir_wb, alu_wb) loads on a rising edge when !i_stall && !o_stall_req. The loaded value is NOP if i_flush, else i_ir_mem / i_alu_mem. Otherwise it holds.
- A flush never cancels the instruction already in WB.
- FSM states are RUN, WAIT and DONE.
  - RUN, non-LDR: o_rf_we = writes-register(ir_wb), wdata = alu_wb. Repeated identical writes while held are permitted.
  - RUN, LDR with i_ld_valid: write i_ld_data, no stall. Go to DONE if i_stall, else stay in RUN.
  - RUN, LDR without valid: o_stall_req=1, cnt←1, go to WAIT.
  - WAIT, i_ld_valid: o_rf_we=1, wdata=i_ld_data, o_stall_req=0. Go to DONE if i_stall, else RUN.
  - WAIT, no valid, cnt==LD_TIMEOUT: o_ld_err=1, o_rf_we=0, o_stall_req=0. Go to DONE if i_stall, else RUN.
  - WAIT, otherwise: o_stall_req=1, cnt++.
  - DONE: o_rf_we=0, o_stall_req=0. Leave to RUN on the first edge where !i_stall. Prevents an LDR held by i_stall from re-triggering.
- i_ld_valid outside an LDR wait (RUN non-LDR, DONE) is ignored.
- o_rd_sel = (opcode(ir_wb)==LDR), independent of state.
- o_rf_waddr = rd(ir_wb) whenever o_rf_we=1.

## Timing
- Reset (rst=0, async) sets:
  - ir_wb=NOP, alu_wb=0, state=RUN, cnt=0
  - all outputs 0 (o_rf_we=0, o_stall_req=0, o_ld_err=0, o_rd_sel=0)
- Reset asserted during WAIT aborts the load: no write, no error.
- Latency: the MEM→WB register is 1 cycle. o_rf_we, o_stall_req and o_ld_err are combinational from state, ir_wb and i_ld_valid, within the same cycle.
- Load timing, with the LDR entering WB in cycle 0:
  - Without valid: o_stall_req is high in cycles 0..LD_TIMEOUT-1 and o_ld_err pulses in cycle LD_TIMEOUT.
  - With valid in cycle k≤LD_TIMEOUT-1: write in cycle k, stall released in cycle k.
- The cnt width is $clog2(LD_TIMEOUT+1) and it never wraps.

## Structure
- Shared package ctrl_pkg holds:
  - opcode constants (OP_LDR, OP_STR, OP_NOP, branch prefix)
  - the NOP encoding and IR_W=16
  - the state enum wb_state_t {RUN, WAIT, DONE}
  - function writes_reg(ir)
- Sub-module wb_ld_timer (load/increment/compare cnt against LD_TIMEOUT, expires flag) is natural. Everything else stays in ctrl_wb_ld.

## Test plan
- Reset mid-WAIT: after reset all outputs read 0, ir_wb=NOP, and the next LDR behaves from RUN.
- ADD r3 (opcode 00001, rd=3), alu=16'h1234, stall 0 → next cycle o_rf_we=1, waddr=3, wdata=16'h1234, o_rd_sel=0.
- LDR r5 with i_ld_valid, data 16'hBEEF, in the same cycle it enters WB → one write of BEEF to r5, o_stall_req never high.
- LD_TIMEOUT=4, LDR r2, valid in cycle 2 → o_stall_req high cycles 0–1, write 16'h00AA in cycle 2, the next instruction enters WB in cycle 3.
- LD_TIMEOUT=4, LDR, no valid → stall cycles 0–3, o_ld_err=1 and o_rf_we=0 in cycle 4, then the pipeline advances.
- LDR completes while i_stall=1 for 3 more cycles → exactly one o_rf_we pulse, FSM in DONE, a late i_ld_valid is ignored. STR/NOP/branch in WB → o_rf_we=0; i_flush → NOP captured.
